// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, sub-arbiter state encoding and the
// algebraic S-box (multiplicative inverse in GF(2^8) followed by the affine map).
package aes_pkg;

  localparam int AES_BYTE_W    = 8;
  localparam int AES_WORD_W    = 32;
  localparam int AES_BLOCK_W   = 128;
  localparam int AES_SUB_LANES = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_D_HOLD = 2'd2;
  localparam logic [1:0] ST_K_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DATA   = ST_DATA,
    D_HOLD = ST_D_HOLD,
    K_HOLD = ST_K_HOLD
  } aes_sub_state_e;

  localparam logic PREF_DATA = 1'b0;
  localparam logic PREF_KEY  = 1'b1;

  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    // a^254 is the inverse for a != 0 and conveniently maps 0 to 0
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = aes_gf_mul(inv, sq);
      sq = aes_gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sub_arbiter_if.sv
// Request/response handshakes between the round datapath / key scheduler (master)
// and the S-box sub-arbiter (slave).
interface aes_sub_arbiter_if;
  import aes_pkg::*;

  logic                   d_valid;
  logic                   d_ready;
  logic [AES_BLOCK_W-1:0] d_in;
  logic                   d_out_valid;
  logic                   d_out_ready;
  logic [AES_BLOCK_W-1:0] d_out;

  logic                   k_valid;
  logic                   k_ready;
  logic [AES_WORD_W-1:0]  k_in;
  logic                   k_out_valid;
  logic                   k_out_ready;
  logic [AES_WORD_W-1:0]  k_out;

  modport master (
    output d_valid, d_in, d_out_ready, k_valid, k_in, k_out_ready,
    input  d_ready, d_out_valid, d_out, k_ready, k_out_valid, k_out
  );

  modport slave (
    input  d_valid, d_in, d_out_ready, k_valid, k_in, k_out_ready,
    output d_ready, d_out_valid, d_out, k_ready, k_out_valid, k_out
  );

endinterface

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  assign out_byte = aes_sbox_calc(in_byte);

endmodule

// File: rtl/aes_sub_lanes.sv
// Four parallel S-box lanes: one 32-bit word in, per-byte substituted word out.
module aes_sub_lanes
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word_in,
  output logic [AES_WORD_W-1:0] word_out
);

  generate
    for (genvar gi = 0; gi < AES_SUB_LANES; gi++) begin : g_lane
      aes_sbox u_sbox (
        .in_byte  (word_in[gi*AES_BYTE_W +: AES_BYTE_W]),
        .out_byte (word_out[gi*AES_BYTE_W +: AES_BYTE_W])
      );
    end
  endgenerate

endmodule

// File: rtl/aes_sub_arbiter.sv
// Shares four S-box lanes between 128-bit SubBytes (four beats) and 32-bit SubWord,
// round-robin per transaction. Define AES_SUB_STATS_EN for the d_grants/k_grants counters.
module aes_sub_arbiter
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  aes_sub_arbiter_if.slave bus
`ifdef AES_SUB_STATS_EN
  ,
  output logic [CNT_W-1:0] d_grants,
  output logic [CNT_W-1:0] k_grants
`endif
);

  aes_sub_state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic       pref_q, pref_d;
  logic [AES_SUB_LANES-2:0][AES_WORD_W-1:0] d_buf_q, d_buf_d;
  logic [AES_SUB_LANES-1:0][AES_WORD_W-1:0] d_out_q, d_out_d;
  logic [AES_WORD_W-1:0] k_out_q, k_out_d;
  logic [AES_WORD_W-1:0] lane_in;
  logic [AES_WORD_W-1:0] lane_out;
  logic idle;
  logic d_accept;
  logic k_accept;

  assign idle     = (state_q == IDLE) && !rst;
  assign d_accept = idle && bus.d_valid && (!bus.k_valid || pref_q == PREF_DATA);
  assign k_accept = idle && bus.k_valid && (!bus.d_valid || pref_q == PREF_KEY);

  assign bus.d_ready     = d_accept;
  assign bus.k_ready     = k_accept;
  assign bus.d_out_valid = (state_q == D_HOLD);
  assign bus.k_out_valid = (state_q == K_HOLD);
  assign bus.d_out       = d_out_q;
  assign bus.k_out       = k_out_q;

  // In DATA, beat n (1..3) consumes latched word n-1, i.e. d_in word n.
  always_comb begin
    lane_in = bus.d_in[AES_WORD_W-1:0];
    if (state_q == DATA) begin
      case (beat_q)
        2'd1:    lane_in = d_buf_q[0];
        2'd2:    lane_in = d_buf_q[1];
        default: lane_in = d_buf_q[2];
      endcase
    end else if (k_accept) begin
      lane_in = bus.k_in;
    end
  end

  aes_sub_lanes u_lanes (
    .word_in  (lane_in),
    .word_out (lane_out)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pref_d  = pref_q;
    d_buf_d = d_buf_q;
    d_out_d = d_out_q;
    k_out_d = k_out_q;
    case (state_q)
      IDLE: begin
        if (d_accept) begin
          d_out_d[0] = lane_out;
          d_buf_d    = bus.d_in[AES_BLOCK_W-1:AES_WORD_W];
          beat_d     = 2'd1;
          pref_d     = PREF_KEY;
          state_d    = DATA;
        end else if (k_accept) begin
          k_out_d = lane_out;
          pref_d  = PREF_DATA;
          state_d = K_HOLD;
        end
      end
      DATA: begin
        d_out_d[beat_q] = lane_out;
        beat_d          = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = D_HOLD;
      end
      D_HOLD: if (bus.d_out_ready) state_d = IDLE;
      K_HOLD: if (bus.k_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      pref_q  <= PREF_DATA;
      d_buf_q <= '0;
      d_out_q <= '0;
      k_out_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pref_q  <= pref_d;
      d_buf_q <= d_buf_d;
      d_out_q <= d_out_d;
      k_out_q <= k_out_d;
    end
  end

`ifdef AES_SUB_STATS_EN
  logic [CNT_W-1:0] d_grants_q, d_grants_d;
  logic [CNT_W-1:0] k_grants_q, k_grants_d;

  always_comb begin
    d_grants_d = d_grants_q + CNT_W'(d_accept);
    k_grants_d = k_grants_q + CNT_W'(k_accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_grants_q <= '0;
      k_grants_q <= '0;
    end else begin
      d_grants_q <= d_grants_d;
      k_grants_q <= k_grants_d;
    end
  end

  assign d_grants = d_grants_q;
  assign k_grants = k_grants_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_aes_sub_arbiter.sv
// Directed and randomized checks of aes_sub_arbiter against a transaction-level model.
// Build with +define+AES_SUB_STATS_EN to also check the grant counters.
`timescale 1ns/1ps
module tb_aes_sub_arbiter;

  localparam int CNT_W    = 16;
  localparam int OWN_NONE = 0;
  localparam int OWN_D    = 1;
  localparam int OWN_K    = 2;
  localparam int D_EDGES  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_sub_arbiter_if bus ();

`ifdef AES_SUB_STATS_EN
  logic [CNT_W-1:0] d_grants;
  logic [CNT_W-1:0] k_grants;
  logic [CNT_W-1:0] s_d_grants;
  logic [CNT_W-1:0] s_k_grants;
`endif

  aes_sub_arbiter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef AES_SUB_STATS_EN
    ,
    .d_grants (d_grants),
    .k_grants (k_grants)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox_tab [256];

  // reference model state
  int         m_owner;
  int         m_wait;
  logic       m_pref_key;
  logic [127:0] m_res_d;
  logic [31:0]  m_res_k;
  int         m_dcnt;
  int         m_kcnt;

  // DUT snapshot taken 1 ns after each falling edge
  logic s_d_ready, s_k_ready, s_d_out_valid, s_k_out_valid;
  logic [127:0] s_d_out;
  logic [31:0]  s_k_out;

  logic [7:0] gseq;
  int         n_g;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_tab[w[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_block(input logic [127:0] b);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = sub_word(b[32*j +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step(input logic r, input logic dv, input logic [127:0] din, input logic kv,
                      input logic [31:0] kin, input logic dor, input logic kor);
    logic exp_dr, exp_kr, d_done, k_done;
    @(negedge clk);
    rst             = r;
    bus.d_valid     = dv;
    bus.d_in        = din;
    bus.k_valid     = kv;
    bus.k_in        = kin;
    bus.d_out_ready = dor;
    bus.k_out_ready = kor;
    #1;
    s_d_ready     = bus.d_ready;
    s_k_ready     = bus.k_ready;
    s_d_out_valid = bus.d_out_valid;
    s_k_out_valid = bus.k_out_valid;
    s_d_out       = bus.d_out;
    s_k_out       = bus.k_out;
`ifdef AES_SUB_STATS_EN
    s_d_grants    = d_grants;
    s_k_grants    = k_grants;
`endif
    exp_dr = !r && m_owner == OWN_NONE && dv && (!kv || !m_pref_key);
    exp_kr = !r && m_owner == OWN_NONE && kv && (!dv || m_pref_key);
    d_done = (m_owner == OWN_D) && (m_wait == 0);
    k_done = (m_owner == OWN_K) && (m_wait == 0);
    check("d_ready", s_d_ready, exp_dr);
    check("k_ready", s_k_ready, exp_kr);
    check("ready_excl", s_d_ready & s_k_ready, 1'b0);
    check("d_out_valid", s_d_out_valid, d_done);
    check("k_out_valid", s_k_out_valid, k_done);
    if (d_done) check("d_out", s_d_out, m_res_d);
    if (k_done) check("k_out", s_k_out, m_res_k);
    if (s_d_ready) begin gseq = {gseq[5:0], 2'b01}; n_g++; end
    if (s_k_ready) begin gseq = {gseq[5:0], 2'b10}; n_g++; end
    @(posedge clk);
    if (r) begin
      m_owner = OWN_NONE; m_wait = 0; m_pref_key = 1'b0; m_dcnt = 0; m_kcnt = 0;
    end else if (m_owner != OWN_NONE) begin
      if (m_wait > 0) begin
        m_wait--;
      end else if (d_done && dor) begin
        $display("[%0t] SubBytes result %h consumed", $time, m_res_d);
        m_owner = OWN_NONE;
      end else if (k_done && kor) begin
        $display("[%0t] SubWord result %h consumed", $time, m_res_k);
        m_owner = OWN_NONE;
      end
    end else if (exp_dr) begin
      m_owner = OWN_D; m_wait = D_EDGES - 1; m_res_d = sub_block(din);
      m_pref_key = 1'b1; m_dcnt++;
    end else if (exp_kr) begin
      m_owner = OWN_K; m_wait = 0; m_res_k = sub_word(kin);
      m_pref_key = 1'b0; m_kcnt++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   inv, s, aff_c;
    logic [127:0] din_inc, held;

    bus.d_valid = 1'b0; bus.d_in = '0; bus.d_out_ready = 1'b0;
    bus.k_valid = 1'b0; bus.k_in = '0; bus.k_out_ready = 1'b0;
    m_owner = OWN_NONE; m_wait = 0; m_pref_key = 1'b0; m_dcnt = 0; m_kcnt = 0;
    m_res_d = '0; m_res_k = '0; gseq = '0; n_g = 0;

    // S-box from first principles: brute-force inverse plus the bitwise affine map
    aff_c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
      sbox_tab[a] = s;
    end

    // reset with both requesters asserting
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand128(), 1'b1, $urandom(), 1'b1, 1'b1);
    check("rst_d_out", s_d_out, '0);
    check("rst_k_out", s_k_out, '0);
`ifdef AES_SUB_STATS_EN
    check("rst_grants", {s_d_grants, s_k_grants}, '0);
`endif

    // contention: D, K, D, K
    gseq = '0; n_g = 0;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, rand128(), 1'b1, $urandom(), 1'b1, 1'b1);
    check("contention_order", gseq, 8'b01100110);
    check("contention_count", n_g, 4);

    // backpressure on the SubBytes output while SubWord waits
    step(1'b0, 1'b1, rand128(), 1'b1, $urandom(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand128(), 1'b1, $urandom(), 1'b0, 1'b0);
    held = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, rand128(), 1'b1, $urandom(), 1'b0, 1'b0);
      if (i == 0) held = s_d_out;
      else check("bp_d_out_stable", s_d_out, held);
      check("bp_k_ready", s_k_ready, 1'b0);
    end
    step(1'b0, 1'b0, rand128(), 1'b1, $urandom(), 1'b1, 1'b0);
    step(1'b0, 1'b0, rand128(), 1'b1, $urandom(), 1'b0, 1'b1);
    check("bp_k_after_release", s_k_ready, 1'b1);
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b0, 1'b1);

    // reset while in DATA beat 2, then a fresh byte-i=i SubBytes
    step(1'b0, 1'b1, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    step(1'b1, 1'b1, rand128(), 1'b1, $urandom(), 1'b1, 1'b1);
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    check("rst_mid_d_out_valid", s_d_out_valid, 1'b0);
    check("rst_mid_d_out", s_d_out, '0);
`ifdef AES_SUB_STATS_EN
    check("rst_mid_grants", {s_d_grants, s_k_grants}, '0);
`endif
    for (int i = 0; i < 16; i++) din_inc[8*i +: 8] = 8'(i);
    step(1'b0, 1'b1, din_inc, 1'b0, $urandom(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
      check("sb_inc_early", s_d_out_valid, 1'b0);
    end
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    check("sb_inc_valid", s_d_out_valid, 1'b1);
    check("sb_inc", s_d_out, 128'h76abd7fe2b670130c56f6bf27b777c63);

    // SubWord lookup
    step(1'b0, 1'b0, rand128(), 1'b1, 32'h00010253, 1'b1, 1'b1);
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    check("subword_valid", s_k_out_valid, 1'b1);
    check("subword", s_k_out, 32'h637c77ed);

    // SubBytes all zero
    step(1'b0, 1'b1, '0, 1'b0, $urandom(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
    check("sb_zero_valid", s_d_out_valid, 1'b1);
    check("sb_zero", s_d_out, {16{8'h63}});

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 99) < 60, rand128(),
           $urandom_range(0, 99) < 60, $urandom(),
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
    end

    step(1'b0, 1'b0, rand128(), 1'b0, $urandom(), 1'b1, 1'b1);
`ifdef AES_SUB_STATS_EN
    check("d_grants", s_d_grants, CNT_W'(m_dcnt));
    check("k_grants", s_k_grants, CNT_W'(m_kcnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_sub_arbiter.md
# aes_sub_arbiter

Shares four `aes_sbox` lookup lanes between two requesters: the AES round datapath, which needs 128-bit SubBytes, and the key-expansion unit, which needs 32-bit SubWord. Each SubBytes transaction runs as four 32-bit beats, and a transaction is never interrupted. Contention is resolved by round-robin arbitration at transaction granularity. The block sits between the round controller / key scheduler and the S-box lanes, and drives results back over valid/ready handshakes.

## Interface
- `CNT_W`, default 16: width of the statistics counters (used only with `AES_SUB_STATS_EN`).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: SubBytes request valid.
- `d_ready` out 1: SubBytes request accepted this cycle.
- `d_in` in 128: state. Byte i is `d_in[8i+7:8i]`.
- `d_out_valid` out 1: SubBytes result valid.
- `d_out_ready` in 1: SubBytes result consumed.
- `d_out` out 128: result. Byte i is S(byte i of `d_in`).
- `k_valid` in 1: SubWord request valid.
- `k_ready` out 1: SubWord request accepted.
- `k_in` in 32: word. Lane j is `k_in[8j+7:8j]`.
- `k_out_valid` out 1: SubWord result valid.
- `k_out_ready` in 1: SubWord result consumed.
- `k_out` out 32: result, per-byte S-box.
- `d_grants`, `k_grants` out CNT_W: accepted-transaction counters (present only with `AES_SUB_STATS_EN`).

## Operation
- **States:**
  - `IDLE`: lanes free; arbitration happens here.
  - `DATA`: beats 1..3 of a SubBytes transaction.
  - `D_HOLD`: SubBytes result held until consumed.
  - `K_HOLD`: SubWord result held until consumed.
- **Arbitration (IDLE only):**
  - A single valid requester wins.
  - If both are valid, the winner is the one indicated by `pref`.
  - `pref` toggles to the other requester on every accepted transaction.
  - Reset value of `pref` is data.
  - `d_ready` and `k_ready` are combinational in `valid`, `state` and `pref`. At most one is high. Both are low outside IDLE.
- **Lane input mux:**
  - IDLE: the winner's word, either `k_in` or `d_in[31:0]`.
  - DATA: the latched word selected by `beat`.
- **SubWord path:**
  - On the accept edge, `k_out` ← lane outputs and the state goes to `K_HOLD`.
  - `k_out_valid` stays high until `k_out_ready`.
  - On that edge the state returns to IDLE.
- **SubBytes path:**
  - On the accept edge:
    - word 0 result is written into `d_out[31:0]`;
    - `d_in[127:32]` is latched;
    - `beat` ← 1;
    - the state goes to DATA.
  - Each DATA cycle writes word `beat` into `d_out[32·beat+31:32·beat]`.
  - After beat 3 the state goes to `D_HOLD` and `d_out_valid` goes high.
  - `d_out_ready` returns the state to IDLE.
- `d_out` and `k_out` are registered and stable while their valid is high.
- **No same-cycle re-accept:** the earliest new accept is one cycle after the output handshake.
- `d_valid` may drop while the block is busy. That has no effect: requests are only sampled in IDLE.

## Timing
- **Reset values:**
  - `d_ready` = `k_ready` = 0 while `rst` is high.
  - `d_out_valid` = `k_out_valid` = 0.
  - `d_out` = 0, `k_out` = 0.
  - State is IDLE, `beat` is 0, `pref` is data.
  - Counters are 0.
- **SubWord latency:** `k_out_valid` is high in the cycle after the accept edge.
- **SubBytes latency:** `d_out_valid` goes high 4 edges after the accept edge, counting the accept edge.
- **Throughput:**
  - Best case is 1 SubWord per 2 cycles, or 1 SubBytes per 5 cycles, with the output ready held high.
- **Backpressure:** a stalled output holds the block in its HOLD state. The other requester waits.
- **Reset mid-transaction** (any state): the next cycle is IDLE with all valids low. The partial result is discarded and no output handshake occurs.
- **Both requesters valid in IDLE:**
  - after reset, data wins;
  - then winners alternate.
  - This bounds the wait for either requester to one transaction.

## Configuration
- **`AES_SUB_STATS_EN` defined:**
  - `d_grants` and `k_grants` count accepted transactions;
  - they wrap at 2^CNT_W;
  - they reset to 0.
- **`AES_SUB_STATS_EN` undefined:**
  - the counter ports and logic are absent;
  - all other behaviour is identical.

## Structure
- **Shared package `aes_pkg`:**
  - state enum (IDLE, DATA, D_HOLD, K_HOLD);
  - `AES_BYTE_W`=8, `AES_WORD_W`=32, `AES_BLOCK_W`=128;
  - `AES_SUB_LANES`=4.
- **Sub-module:**
  - `aes_sub_lanes` wraps four `aes_sbox` instances, mapping a 32-bit word in to a 32-bit word out.
  - The arbiter instantiates it once.

## Test plan
- **SubWord lookup:**
  - Stimulus: `k_in`=0x00010253, `k_out_ready`=1.
  - Response: `k_out`=0x637c77ed, with `k_out_valid` high one cycle after the accept.
- **SubBytes, all zero:**
  - Stimulus: `d_in`=0.
  - Response: `d_out`=0x63 repeated 16 times, with `d_out_valid` high 4 edges after the accept, counting the accept edge.
- **SubBytes, byte i = i:**
  - Stimulus: `d_in` with byte i = i.
  - Response: bytes 0..15 = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
- **Contention:**
  - Stimulus: `d_valid` and `k_valid` held high.
  - Response: grant order is D, K, D, K, with `d_ready` and `k_ready` never high together.
- **Backpressure:**
  - Stimulus: `d_out_ready`=0 for 10 cycles while `k_valid`=1.
  - Response: `k_ready` stays 0 and `d_out` is stable; after release, K is accepted 1 cycle later.
- **Reset in DATA, beat 2:**
  - Response: next cycle `d_out_valid`=0 and the state is IDLE; a fresh request then completes normally.
  - With `AES_SUB_STATS_EN`, counters read 0.
